// File: rtl/io_debounce_irq_if.sv
// Register-map side of the input conditioning stage: controls in, debounced levels and status out.
// The master modport belongs to the register map, the slave modport to io_debounce_irq.
interface io_debounce_irq_if #(
    parameter int N_SW  = 8,
    parameter int N_BTN = 5
);
    logic [N_SW-1:0]  deb_switch_ena;
    logic [N_BTN-1:0] deb_button_ena;
    logic [4:0]       deb_time;
    logic [N_SW-1:0]  int_switch_ena;
    logic [N_BTN-1:0] int_button_ena;
    logic [N_SW-1:0]  int_switch_clr;
    logic [N_BTN-1:0] int_button_clr;
    logic [N_BTN-1:0] button_posedge;
    logic [N_BTN-1:0] button_negedge;
    logic [N_SW-1:0]  switch_deb;
    logic [N_BTN-1:0] button_deb;
    logic [N_SW-1:0]  int_switch_sts;
    logic [N_BTN-1:0] int_button_sts;

    modport master (
        output deb_switch_ena,
        output deb_button_ena,
        output deb_time,
        output int_switch_ena,
        output int_button_ena,
        output int_switch_clr,
        output int_button_clr,
        output button_posedge,
        output button_negedge,
        input  switch_deb,
        input  button_deb,
        input  int_switch_sts,
        input  int_button_sts
    );

    modport slave (
        input  deb_switch_ena,
        input  deb_button_ena,
        input  deb_time,
        input  int_switch_ena,
        input  int_button_ena,
        input  int_switch_clr,
        input  int_button_clr,
        input  button_posedge,
        input  button_negedge,
        output switch_deb,
        output button_deb,
        output int_switch_sts,
        output int_button_sts
    );
endinterface

// File: rtl/io_debounce_irq.sv
// Synchronises and debounces board switches/buttons, detects edges and keeps sticky
// interrupt status bits; all outputs are registered.
module io_debounce_irq #(
    parameter int N_SW     = 8,
    parameter int N_BTN    = 5,
    parameter int TICK_DIV = 100000
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [N_SW-1:0]  switch_raw,
    input  logic [N_BTN-1:0] button_raw,
    io_debounce_irq_if.slave regs,
    output logic             irq
);
    localparam int N_ALL = N_SW + N_BTN;
    localparam int CW    = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0]    count;
    logic             tick;
    logic [N_ALL-1:0] sync1;
    logic [N_ALL-1:0] sync2;
    logic [N_ALL-1:0] deb_ena;
    logic [N_ALL-1:0] stable;
    logic [N_ALL-1:0] stable_d;
    logic [N_ALL-1:0] rise;
    logic [N_ALL-1:0] fall;
    logic [5:0]       deb_limit;
    logic [N_SW-1:0]  switch_event;
    logic [N_BTN-1:0] button_event;
    logic [N_SW-1:0]  switch_sts;
    logic [N_BTN-1:0] button_sts;

    // Free-running prescaler; input activity never restarts it.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            count <= '0;
        end else if (count == TICK_LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == TICK_LAST);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {button_raw, switch_raw};
            sync2 <= sync1;
        end
    end

    assign deb_ena   = {regs.deb_button_ena, regs.deb_switch_ena};
    assign deb_limit = {1'b0, regs.deb_time};

    // Any cycle where the input agrees with the stable level restarts the window.
    for (genvar i = 0; i < N_ALL; i++) begin : g_deb
        logic [5:0] cnt;
        logic       level;

        always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (!deb_ena[i]) begin
                cnt   <= '0;
                level <= sync2[i];
            end else if (sync2[i] == level) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt < deb_limit) begin
                    cnt <= cnt + 6'd1;
                end else begin
                    cnt   <= '0;
                    level <= sync2[i];
                end
            end
        end

        assign stable[i] = level;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

    assign switch_event = (rise[N_SW-1:0] | fall[N_SW-1:0]) & regs.int_switch_ena;
    assign button_event = ((rise[N_ALL-1:N_SW] & regs.button_posedge) |
                           (fall[N_ALL-1:N_SW] & regs.button_negedge)) & regs.int_button_ena;

    // A new event in the same cycle as its clear pulse keeps the bit set.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            switch_sts <= '0;
            button_sts <= '0;
            irq        <= 1'b0;
        end else begin
            switch_sts <= (switch_sts & ~regs.int_switch_clr) | switch_event;
            button_sts <= (button_sts & ~regs.int_button_clr) | button_event;
            irq        <= |{switch_sts, button_sts};
        end
    end

    assign regs.switch_deb     = stable[N_SW-1:0];
    assign regs.button_deb     = stable[N_ALL-1:N_SW];
    assign regs.int_switch_sts = switch_sts;
    assign regs.int_button_sts = button_sts;
endmodule

// File: tb/tb_io_debounce_irq.sv
// Directed bench for io_debounce_irq with TICK_DIV=4; each task drives one scenario and checks inline.
module tb_io_debounce_irq;
    localparam int N_SW  = 8;
    localparam int N_BTN = 5;

    logic             ACLK = 1'b0;
    logic             ARESET = 1'b1;
    logic [N_SW-1:0]  switch_raw = '0;
    logic [N_BTN-1:0] button_raw = '0;
    logic             irq;

    int tests = 0;
    int failures = 0;

    io_debounce_irq_if #(.N_SW(N_SW), .N_BTN(N_BTN)) regs ();

    io_debounce_irq #(.N_SW(N_SW), .N_BTN(N_BTN), .TICK_DIV(4)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .switch_raw (switch_raw),
        .button_raw (button_raw),
        .regs       (regs.slave),
        .irq        (irq)
    );

    always #5 ACLK = ~ACLK;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic test_reset;
        int n;
        regs.deb_switch_ena = 8'hFF;
        regs.deb_button_ena = 5'h1F;
        regs.deb_time       = 5'd0;
        regs.int_switch_ena = '0;
        regs.int_button_ena = '0;
        regs.int_switch_clr = '0;
        regs.int_button_clr = '0;
        regs.button_posedge = '0;
        regs.button_negedge = '0;
        switch_raw = 8'hFF;
        button_raw = '0;
        ARESET = 1'b1;
        step(3);
        tests++;
        if ({regs.switch_deb, regs.button_deb, regs.int_switch_sts, regs.int_button_sts, irq} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: sw_deb=%h btn_deb=%h sw_sts=%h btn_sts=%h irq=%b, want all 0",
                     regs.switch_deb, regs.button_deb, regs.int_switch_sts, regs.int_button_sts, irq);
        end
        // Prescaler restarts at 0: s2 valid after edge 2, first tick commits at edge 4.
        ARESET = 1'b0;
        n = 0;
        while (regs.switch_deb !== 8'hFF && n < 12) begin
            step(1);
            n++;
        end
        tests++;
        if (n != 4) begin
            failures++;
            $display("[TB] FAIL reset_commit: switch_deb=FF after %0d cycles, want 4", n);
        end
        step(4);
        tests++;
        if (regs.int_switch_sts !== 8'h00 || regs.int_button_sts !== 5'h00 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_no_sts: sw_sts=%h btn_sts=%h irq=%b, want 0/0/0",
                     regs.int_switch_sts, regs.int_button_sts, irq);
        end
    endtask

    task automatic test_bounce;
        int rises;
        int first;
        logic prev;
        regs.deb_time       = 5'd3;
        regs.deb_button_ena = 5'h1F;
        button_raw = '0;
        step(2);
        button_raw[0] = 1'b1;
        step(2);
        button_raw[0] = 1'b0;
        step(2);
        button_raw[0] = 1'b1;
        rises = 0;
        first = 0;
        prev  = regs.button_deb[0];
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (regs.button_deb[0] === 1'b1 && prev === 1'b0) begin
                rises++;
                if (first == 0) first = i;
            end
            prev = regs.button_deb[0];
        end
        tests++;
        if (rises != 1) begin
            failures++;
            $display("[TB] FAIL bounce_rises: %0d rises, want 1", rises);
        end
        // s2 differs from edge 2; 4 ticks needed, first tick edge lands on edge 3..6.
        tests++;
        if (first < 15 || first > 18) begin
            failures++;
            $display("[TB] FAIL bounce_latency: rise after %0d cycles, want 15..18", first);
        end
    endtask

    task automatic test_edge_select;
        regs.deb_button_ena = '0;
        regs.int_button_ena = '0;
        button_raw = '0;
        step(6);
        regs.int_button_clr = 5'h1F;
        step(1);
        regs.int_button_clr = '0;
        regs.int_button_ena = 5'h1F;
        regs.button_posedge = 5'h01;
        regs.button_negedge = 5'h02;
        step(2);
        button_raw[1:0] = 2'b11;
        step(3);
        tests++;
        if (regs.int_button_sts !== 5'h00) begin
            failures++;
            $display("[TB] FAIL edge_early: btn_sts=%h, want 00", regs.int_button_sts);
        end
        step(1);
        tests++;
        if (regs.int_button_sts !== 5'h01 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL edge_rise: btn_sts=%h irq=%b, want 01/0", regs.int_button_sts, irq);
        end
        step(1);
        tests++;
        if (irq !== 1'b1) begin
            failures++;
            $display("[TB] FAIL edge_irq: irq=%b, want 1", irq);
        end
        button_raw[1:0] = 2'b00;
        step(4);
        tests++;
        if (regs.int_button_sts !== 5'h03) begin
            failures++;
            $display("[TB] FAIL edge_fall: btn_sts=%h, want 03", regs.int_button_sts);
        end
    endtask

    task automatic test_clear_collision;
        regs.int_button_ena = '0;
        regs.int_button_clr = 5'h1F;
        step(1);
        regs.int_button_clr = '0;
        regs.deb_switch_ena = '0;
        regs.int_switch_ena = 8'h04;
        step(2);
        tests++;
        if (irq !== 1'b0 || regs.int_button_sts !== 5'h00) begin
            failures++;
            $display("[TB] FAIL clr_buttons: btn_sts=%h irq=%b, want 00/0", regs.int_button_sts, irq);
        end
        switch_raw[2] = 1'b0;
        step(5);
        tests++;
        if (regs.int_switch_sts !== 8'h04) begin
            failures++;
            $display("[TB] FAIL clr_first_set: sw_sts=%h, want 04", regs.int_switch_sts);
        end
        // Rising event reaches the status register on the 4th edge; clear it in that same cycle.
        switch_raw[2] = 1'b1;
        step(3);
        regs.int_switch_clr = 8'h04;
        step(1);
        tests++;
        if (regs.int_switch_sts !== 8'h04) begin
            failures++;
            $display("[TB] FAIL clr_collision: sw_sts=%h, want 04", regs.int_switch_sts);
        end
        step(1);
        regs.int_switch_clr = '0;
        tests++;
        if (regs.int_switch_sts !== 8'h00 || irq !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clr_clear: sw_sts=%h irq=%b, want 00/1", regs.int_switch_sts, irq);
        end
        step(1);
        tests++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clr_irq_fall: irq=%b, want 0", irq);
        end
    endtask

    task automatic test_bypass_latency;
        regs.int_switch_ena = 8'h01;
        step(2);
        switch_raw[0] = 1'b0;
        step(2);
        tests++;
        if (regs.switch_deb[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bypass_early: switch_deb[0]=%b, want 1", regs.switch_deb[0]);
        end
        step(1);
        tests++;
        if (regs.switch_deb[0] !== 1'b0 || regs.int_switch_sts !== 8'h00) begin
            failures++;
            $display("[TB] FAIL bypass_deb: switch_deb[0]=%b sw_sts=%h, want 0/00",
                     regs.switch_deb[0], regs.int_switch_sts);
        end
        step(1);
        tests++;
        if (regs.int_switch_sts !== 8'h01 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bypass_sts: sw_sts=%h irq=%b, want 01/0", regs.int_switch_sts, irq);
        end
        step(1);
        tests++;
        if (irq !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bypass_irq: irq=%b, want 1", irq);
        end
    endtask

    task automatic test_mid_reset;
        int n;
        regs.deb_button_ena = 5'h1F;
        regs.deb_time       = 5'd3;
        button_raw[2] = 1'b1;
        step(10);
        tests++;
        if (regs.button_deb[2] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_counting: button_deb[2]=%b, want 0", regs.button_deb[2]);
        end
        @(posedge ACLK);
        #2;
        ARESET = 1'b1;
        #1;
        tests++;
        if ({regs.switch_deb, regs.button_deb, regs.int_switch_sts, regs.int_button_sts, irq} !== '0) begin
            failures++;
            $display("[TB] FAIL mid_async: sw_deb=%h btn_deb=%h sw_sts=%h btn_sts=%h irq=%b, want all 0",
                     regs.switch_deb, regs.button_deb, regs.int_switch_sts, regs.int_button_sts, irq);
        end
        step(3);
        ARESET = 1'b0;
        // Prescaler from 0: ticks on edges 4, 8, 12, 16; the 4th tick commits.
        n = 0;
        while (regs.button_deb[2] !== 1'b1 && n < 30) begin
            step(1);
            n++;
        end
        tests++;
        if (n != 16) begin
            failures++;
            $display("[TB] FAIL mid_restart: button_deb[2] rose after %0d cycles, want 16", n);
        end
        step(2);
        tests++;
        if (irq !== 1'b0 || regs.int_switch_sts !== 8'h00 || regs.int_button_sts !== 5'h00) begin
            failures++;
            $display("[TB] FAIL mid_quiet: sw_sts=%h btn_sts=%h irq=%b, want 00/00/0",
                     regs.int_switch_sts, regs.int_button_sts, irq);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_edge_select();
        test_clear_collision();
        test_bypass_latency();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
